// File: rtl/flash_responder.sv
// SPI mode-0 read-only serial-flash emulator: oversamples the flash link on clk,
// decodes READ + address and streams memory bytes MSB-first on flash_miso.
module flash_responder #(
  parameter int unsigned ADDR_W      = 24,
  parameter logic [7:0]  READ_OPCODE = 8'h03,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flash_clk,
  input  logic              flash_cs_n,
  input  logic              flash_mosi,
  output logic              flash_miso,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_valid,
  output logic              busy,
  output logic              cmd_err,
  output logic              underrun
);
  localparam int unsigned CNT_W = $clog2(ADDR_W);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_IGNORE = 3'd4;

  logic [SYNC_STAGES-1:0] r_clk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_clk_prev;
  logic [2:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [ADDR_W-2:0]      r_sr;
  logic [ADDR_W-1:0]      r_addr, r_maddr;
  logic [2:0]             r_bit;
  logic [6:0]             r_shift;
  logic [7:0]             r_hold;
  logic                   r_ready;
  logic [1:0]             r_outst;
  logic                   r_miso, r_req, r_busy, r_err, r_unr;

  logic                   w_sclk, w_cs_n, w_mosi, w_rise, w_fall;
  logic [ADDR_W-1:0]      w_sr_in;
  logic [2:0]             w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [ADDR_W-2:0]      w_sr_nxt;
  logic [ADDR_W-1:0]      w_addr_nxt, w_maddr_nxt;
  logic [2:0]             w_bit_nxt;
  logic [6:0]             w_shift_nxt;
  logic [7:0]             w_hold_nxt, w_byte;
  logic                   w_ready_nxt, w_take, w_issue, w_ret;
  logic [1:0]             w_outst_nxt;
  logic                   w_miso_nxt, w_req_nxt, w_err_nxt, w_unr_nxt;

  assign w_sclk  = r_clk_sync[SYNC_STAGES-1];
  assign w_cs_n  = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi  = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise  = w_sclk & ~r_clk_prev;
  assign w_fall  = ~w_sclk & r_clk_prev;
  assign w_sr_in = {r_sr, w_mosi};

  // Next-state and datapath; an outstanding count lets stale (pre-underrun) returns be dropped
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sr_nxt    = r_sr;
    w_addr_nxt  = r_addr;
    w_maddr_nxt = r_maddr;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_hold_nxt  = r_hold;
    w_ready_nxt = r_ready;
    w_outst_nxt = r_outst;
    w_miso_nxt  = r_miso;
    w_req_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_unr_nxt   = 1'b0;
    w_take      = 1'b0;
    w_issue     = 1'b0;
    w_ret       = 1'b0;
    w_byte      = r_hold;
    if (w_cs_n) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_bit_nxt   = '0;
      w_ready_nxt = 1'b0;
      w_outst_nxt = '0;
      w_miso_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_CMD;
          w_cnt_nxt   = '0;
        end
        ST_CMD: if (w_rise) begin
          w_sr_nxt = w_sr_in[ADDR_W-2:0];
          if (r_cnt == CNT_W'(7)) begin
            w_cnt_nxt = '0;
            if (w_sr_in[7:0] == READ_OPCODE) begin
              w_state_nxt = ST_ADDR;
            end else begin
              w_state_nxt = ST_IGNORE;
              w_err_nxt   = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_ADDR: if (w_rise) begin
          w_sr_nxt = w_sr_in[ADDR_W-2:0];
          if (r_cnt == CNT_W'(ADDR_W - 1)) begin
            w_cnt_nxt   = '0;
            w_addr_nxt  = w_sr_in;
            w_maddr_nxt = w_sr_in;
            w_req_nxt   = 1'b1;
            w_outst_nxt = 2'd1;
            w_ready_nxt = 1'b0;
            w_bit_nxt   = '0;
            w_state_nxt = ST_DATA;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          w_take = mem_valid && (r_outst == 2'd1);
          w_ret  = mem_valid && (r_outst != 2'd0);
          if (w_take) begin
            w_hold_nxt  = mem_rdata;
            w_ready_nxt = 1'b1;
            w_byte      = mem_rdata;
          end
          if (w_fall) begin
            w_bit_nxt = r_bit + 3'd1;
            if (r_bit == 3'd0) begin
              w_issue     = 1'b1;
              w_addr_nxt  = r_addr + ADDR_W'(1);
              w_maddr_nxt = r_addr + ADDR_W'(1);
              w_req_nxt   = 1'b1;
              if (r_ready || w_take) begin
                w_shift_nxt = w_byte[6:0];
                w_miso_nxt  = w_byte[7];
                w_ready_nxt = 1'b0;
              end else begin
                w_shift_nxt = '0;
                w_miso_nxt  = 1'b0;
                w_unr_nxt   = 1'b1;
              end
            end else begin
              w_shift_nxt = {r_shift[5:0], 1'b0};
              w_miso_nxt  = r_shift[6];
            end
          end
          w_outst_nxt = r_outst + 2'(w_issue) - 2'(w_ret);
        end
        ST_IGNORE: w_miso_nxt = 1'b0;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_clk_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_clk_prev  <= 1'b0;
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_sr        <= '0;
      r_addr      <= '0;
      r_maddr     <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_ready     <= 1'b0;
      r_outst     <= '0;
      r_miso      <= 1'b0;
      r_req       <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_unr       <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], flash_clk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], flash_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], flash_mosi};
      r_clk_prev  <= w_sclk;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sr        <= w_sr_nxt;
      r_addr      <= w_addr_nxt;
      r_maddr     <= w_maddr_nxt;
      r_bit       <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_hold      <= w_hold_nxt;
      r_ready     <= w_ready_nxt;
      r_outst     <= w_outst_nxt;
      r_miso      <= w_miso_nxt;
      r_req       <= w_req_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_err       <= w_err_nxt;
      r_unr       <= w_unr_nxt;
    end
  end

  assign flash_miso = r_miso;
  assign mem_req    = r_req;
  assign mem_addr   = r_maddr;
  assign busy       = r_busy;
  assign cmd_err    = r_err;
  assign underrun   = r_unr;

endmodule

// File: tb/tb_flash_responder.sv
// Bench for flash_responder: drives a mode-0 flash master, serves an in-order
// memory with configurable first-request latency, and checks against a byte-level model.
module tb_flash_responder;
  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        reset, flash_clk, flash_cs_n, flash_mosi;
  logic        flash_miso, mem_req, busy, cmd_err, underrun;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_valid = 1'b0;

  int checks = 0, failures = 0;
  int err_cnt = 0, unr_cnt = 0, cyc = 0, last_due = -100, lat_first = 1;
  logic first_req = 1'b0, miso_live = 1'b0, first_bit = 1'b1;
  logic [23:0] exp_addr_q[$];
  typedef struct {logic [23:0] addr; int due;} resp_t;
  resp_t rq[$];
  logic [7:0] rx [0:3];

  flash_responder dut (
    .clk(clk), .reset(reset), .flash_clk(flash_clk), .flash_cs_n(flash_cs_n),
    .flash_mosi(flash_mosi), .flash_miso(flash_miso), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .busy(busy), .cmd_err(cmd_err), .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (a == 24'h000010) return 8'hA5;
    if (a == 24'h000011) return 8'h3C;
    return 8'(a[7:0] * 8'd7 + 8'h11);
  endfunction

  // A byte that started during an underrun goes out as all zeros
  function automatic logic [7:0] exp_byte(input logic [23:0] a, input int k, input logic unr0);
    if (unr0 && k == 0) return 8'h00;
    return mem_byte(a + 24'(k));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // In-order memory: first request of a transfer uses lat_first, later ones 1 clk
  always @(negedge clk) begin
    int lat;
    int d;
    if (reset === 1'b1 && mem_req === 1'b1) begin
      lat = first_req ? lat_first : 1;
      first_req = 1'b0;
      d = cyc + lat - 1;
      if (d <= last_due) d = last_due + 1;
      rq.push_back('{mem_addr, d});
      last_due = d;
    end
    mem_valid = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      mem_valid = 1'b1;
      mem_rdata = mem_byte(rq[0].addr);
      void'(rq.pop_front());
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("rst_miso", flash_miso, 0);
      check("rst_req", mem_req, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_err", cmd_err, 0);
      check("rst_unr", underrun, 0);
    end else begin
      if (mem_req === 1'b1) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_mem_req actual=%0h expected=none t=%0t", mem_addr, $time);
        end else begin
          check("mem_addr", mem_addr, exp_addr_q.pop_front());
        end
      end
      if (cmd_err === 1'b1) err_cnt++;
      if (underrun === 1'b1) unr_cnt++;
      if (!miso_live) check("miso_quiet", flash_miso, 0);
    end
  end

  task automatic start_xfer();
    @(negedge clk);
    flash_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    first_bit = 1'b1;
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    if (!first_bit) begin
      @(negedge clk);
      flash_clk = 1'b0;
    end
    first_bit  = 1'b0;
    flash_mosi = b;
    repeat (HALF) @(negedge clk);
    flash_clk = 1'b1;
    s = flash_miso;
    repeat (HALF - 1) @(negedge clk);
  endtask

  task automatic end_xfer();
    @(negedge clk);
    flash_cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
    flash_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // abort_at != 0: raise cs_n after that many header bits
  task automatic do_read(input logic [23:0] a, input int nbytes, input int abort_at);
    logic s;
    logic [31:0] hdr;
    int n_hdr;
    hdr = {8'h03, a};
    n_hdr = (abort_at != 0) ? abort_at : 32;
    err_cnt = 0;
    unr_cnt = 0;
    if (abort_at == 0)
      for (int i = 0; i <= nbytes; i++) exp_addr_q.push_back(a + 24'(i));
    first_req = 1'b1;
    start_xfer();
    for (int i = 0; i < n_hdr; i++) bit_xfer(hdr[31-i], s);
    if (abort_at == 0) begin
      check("busy_active", busy, 1);
      miso_live = 1'b1;
      for (int k = 0; k < nbytes; k++)
        for (int j = 7; j >= 0; j--) begin
          bit_xfer(1'b0, s);
          rx[k][j] = s;
        end
    end
    end_xfer();
    miso_live = 1'b0;
  endtask

  task automatic end_checks(input int exp_unr);
    check("req_count", exp_addr_q.size(), 0);
    check("underrun_cnt", unr_cnt, exp_unr);
    check("cmd_err_cnt", err_cnt, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    logic s;
    logic [31:0] hdr;
    reset = 1'b0;
    flash_clk = 1'b0;
    flash_cs_n = 1'b1;
    flash_mosi = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      flash_clk  = 1'($urandom_range(0, 1));
      flash_cs_n = 1'($urandom_range(0, 1));
      flash_mosi = 1'($urandom_range(0, 1));
    end
    flash_clk = 1'b0;
    flash_cs_n = 1'b1;
    flash_mosi = 1'b0;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("busy_after_reset", busy, 0);

    // READ 000010, two bytes
    do_read(24'h000010, 2, 0);
    check("rd10_b0_lit", rx[0], 8'hA5);
    check("rd10_b1_lit", rx[1], 8'h3C);
    for (int k = 0; k < 2; k++) check("rd10_model", rx[k], exp_byte(24'h000010, k, 1'b0));
    end_checks(0);

    // Unsupported opcode 9F
    err_cnt = 0;
    hdr = {8'h9F, 24'h000010};
    start_xfer();
    for (int i = 0; i < 32; i++) begin
      bit_xfer(hdr[31-i], s);
      if (i == 6) check("err_before_8th", err_cnt, 0);
      if (i == 7) check("err_after_8th", err_cnt, 1);
    end
    check("busy_ignore", busy, 1);
    @(negedge clk);
    flash_cs_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("busy_hold", busy, 1);
    @(negedge clk);
    check("busy_drop", busy, 0);
    repeat (HALF) @(negedge clk);
    flash_clk = 1'b0;
    repeat (4) @(negedge clk);
    check("err_total", err_cnt, 1);
    check("no_req_9f", exp_addr_q.size(), 0);

    // Address wrap at FFFFFF
    do_read(24'hFFFFFF, 2, 0);
    check("wrap_b0_lit", rx[0], 8'h0A);
    check("wrap_b1_lit", rx[1], 8'h11);
    for (int k = 0; k < 2; k++) check("wrap_model", rx[k], exp_byte(24'hFFFFFF, k, 1'b0));
    end_checks(0);

    // Slow first fetch forces an underrun on byte 0
    lat_first = 6;
    do_read(24'h000020, 2, 0);
    lat_first = 1;
    check("slow_b0_lit", rx[0], 8'h00);
    check("slow_b1_lit", rx[1], 8'hF8);
    for (int k = 0; k < 2; k++) check("slow_model", rx[k], exp_byte(24'h000020, k, 1'b1));
    end_checks(1);

    // Abort after 20 address bits, then a clean READ 000004
    do_read(24'h0ABCDE, 0, 28);
    check("abort_err", err_cnt, 0);
    check("abort_unr", unr_cnt, 0);
    check("abort_busy", busy, 0);
    do_read(24'h000004, 1, 0);
    check("rd4_lit", rx[0], 8'h2D);
    check("rd4_model", rx[0], exp_byte(24'h000004, 0, 1'b0));
    end_checks(0);

    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
